// File: rtl/mcore_pkg.sv
// Shared mcore definitions: arbiter state encoding, default master count and
// the round-robin selection helper used by the memory arbiter.
package mcore_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int MCORE_ARB_NUM_REQ = 3;

    // Upper bound on masters the helper can scan; the arbiter supports 2..8.
    localparam int RR_MAX_REQ = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Return the first requesting master at or after ptr, scanning cyclically
    // over the first num masters. valid is low when nobody is requesting.
    function automatic rr_pick_t rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         num);
        rr_pick_t   res;
        logic [3:0] j;
        res.valid = 1'b0;
        res.idx   = 3'd0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            j = {1'b0, ptr} + 4'(k);
            if (int'(j) >= num) begin
                j = j - 4'(num);
            end else begin
                j = j;
            end
            if ((k < num) && !res.valid && req[j[2:0]]) begin
                res.valid = 1'b1;
                res.idx   = j[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mcore_arb_route_fifo.sv
// Route FIFO for the memory arbiter: remembers which master owns each
// granted-but-unanswered transaction so responses return in issue order.
module mcore_arb_route_fifo
    import mcore_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage, wrapping pointers (DEPTH is a power of two) and occupancy count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mcore_mem_arbiter.sv
// Round-robin arbiter sharing the mcore external memory port between the
// internal masters; responses are routed back through an in-order FIFO.
module mcore_mem_arbiter
    import mcore_pkg::*;
#(
    parameter int NUM_REQ         = MCORE_ARB_NUM_REQ,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_REQ-1:0]             m_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_REQ-1:0]             m_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  m_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] m_be,
    output logic [NUM_REQ-1:0]             m_gnt,
    output logic [NUM_REQ-1:0]             m_rsp_valid,
    output logic [DATA_WIDTH-1:0]          m_rsp_rdata,
    output logic                           m_rsp_error,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_we,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [DATA_WIDTH/8-1:0]        mem_be,
    input  logic                           mem_gnt,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_rdata,
    input  logic                           mem_rsp_error,
    output logic                           unexp_rsp
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t       state_r;
    logic [IDX_W-1:0] hold_sel_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic             unexp_rsp_r;

    rr_pick_t         pick_s;
    logic [IDX_W-1:0] cur_sel_s;
    logic             cur_valid_s;
    logic [IDX_W-1:0] next_ptr_s;
    logic             below_max_s;
    logic             grant_fire_s;
    logic             rsp_fire_s;

    logic [IDX_W-1:0] fifo_head_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    assign pick_s       = rr_pick(8'(m_req), 3'(rr_ptr_r), NUM_REQ);
    assign below_max_s  = (fifo_count_s < CNT_W'(MAX_OUTSTANDING));
    assign mem_req      = cur_valid_s && !areset;
    assign grant_fire_s = mem_req && mem_gnt;
    assign rsp_fire_s   = mem_rsp_valid && !fifo_empty_s && !areset;
    assign next_ptr_s   = (cur_sel_s == LAST_IDX) ? IDX_W'(0) : cur_sel_s + IDX_W'(1);
    assign unexp_rsp    = unexp_rsp_r;

    // Choose the master that owns the memory port this cycle.
    always_comb begin
        cur_sel_s   = IDX_W'(0);
        cur_valid_s = 1'b0;
        case (state_r)
            ARB: begin
                cur_sel_s   = IDX_W'(pick_s.idx);
                cur_valid_s = pick_s.valid && below_max_s;
            end
            HOLD: begin
                cur_sel_s   = hold_sel_r;
                cur_valid_s = 1'b1;
            end
            default: begin
                cur_sel_s   = IDX_W'(0);
                cur_valid_s = 1'b0;
            end
        endcase
    end

    // Request channel mux; fields read as zero whenever no request is presented.
    always_comb begin
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_we    = 1'b0;
        mem_wdata = {DATA_WIDTH{1'b0}};
        mem_be    = {BE_W{1'b0}};
        if (mem_req) begin
            mem_addr  = m_addr[int'(cur_sel_s)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we    = m_we[cur_sel_s];
            mem_wdata = m_wdata[int'(cur_sel_s)*DATA_WIDTH +: DATA_WIDTH];
            mem_be    = m_be[int'(cur_sel_s)*BE_W +: BE_W];
        end else begin
            mem_addr  = {ADDR_WIDTH{1'b0}};
        end
    end

    // Grant strobe back to the winning master, same cycle as mem_gnt.
    always_comb begin
        m_gnt = {NUM_REQ{1'b0}};
        if (grant_fire_s) begin
            m_gnt[cur_sel_s] = 1'b1;
        end else begin
            m_gnt = {NUM_REQ{1'b0}};
        end
    end

    // Response routing to the FIFO head owner; data is zeroed when not routed.
    always_comb begin
        m_rsp_valid = {NUM_REQ{1'b0}};
        m_rsp_rdata = {DATA_WIDTH{1'b0}};
        m_rsp_error = 1'b0;
        if (rsp_fire_s) begin
            m_rsp_valid[fifo_head_s] = 1'b1;
            m_rsp_rdata              = mem_rsp_rdata;
            m_rsp_error              = mem_rsp_error;
        end else begin
            m_rsp_valid = {NUM_REQ{1'b0}};
        end
    end

    // Arbitration FSM: ARB picks a master, HOLD freezes it until mem_gnt.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r    <= ARB;
            hold_sel_r <= IDX_W'(0);
            rr_ptr_r   <= IDX_W'(0);
        end else begin
            case (state_r)
                ARB: begin
                    if (cur_valid_s && mem_gnt) begin
                        rr_ptr_r <= next_ptr_s;
                    end else if (cur_valid_s) begin
                        state_r    <= HOLD;
                        hold_sel_r <= cur_sel_s;
                    end else begin
                        state_r <= ARB;
                    end
                end
                HOLD: begin
                    if (mem_gnt) begin
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ARB;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            unexp_rsp_r <= 1'b0;
        end else if (mem_rsp_valid && fifo_empty_s) begin
            unexp_rsp_r <= 1'b1;
        end else begin
            unexp_rsp_r <= unexp_rsp_r;
        end
    end

    mcore_arb_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_route_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (grant_fire_s && !fifo_full_s),
        .push_data (cur_sel_s),
        .pop       (rsp_fire_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_mcore_mem_arbiter.sv
// Directed scoreboard bench for mcore_mem_arbiter: stimulus queues expected
// grants/responses, an independent monitor matches them as the DUT emits them.
module tb_mcore_mem_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic [2:0]  m_req;
    logic [95:0] m_addr;
    logic [2:0]  m_we;
    logic [95:0] m_wdata;
    logic [11:0] m_be;
    logic [2:0]  m_gnt;
    logic [2:0]  m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_error;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_error;
    logic        unexp_rsp;

    mcore_mem_arbiter dut (
        .aclk          (aclk),
        .areset        (areset),
        .m_req         (m_req),
        .m_addr        (m_addr),
        .m_we          (m_we),
        .m_wdata       (m_wdata),
        .m_be          (m_be),
        .m_gnt         (m_gnt),
        .m_rsp_valid   (m_rsp_valid),
        .m_rsp_rdata   (m_rsp_rdata),
        .m_rsp_error   (m_rsp_error),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_gnt       (mem_gnt),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_error (mem_rsp_error),
        .unexp_rsp     (unexp_rsp)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
    } gnt_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    gnt_t exp_gnt_q[$];
    rsp_t exp_rsp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    logic [31:0] tb_addr  [3];
    logic        tb_we    [3];
    logic [31:0] tb_wdata [3];
    logic [3:0]  tb_be    [3];

    gnt_t       mon_g;
    rsp_t       mon_r;
    logic [2:0] mon_oh;

    int fair_order [6] = '{1, 2, 0, 1, 2, 0};
    int full_order [4] = '{1, 2, 0, 1};
    int burst_order[3] = '{1, 2, 0};

    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [31:0] a, input logic we,
                              input logic [31:0] wd, input logic [3:0] be);
        m_addr[i*32 +: 32]  = a;
        m_we[i]             = we;
        m_wdata[i*32 +: 32] = wd;
        m_be[i*4 +: 4]      = be;
        tb_addr[i]  = a;
        tb_we[i]    = we;
        tb_wdata[i] = wd;
        tb_be[i]    = be;
    endtask

    task automatic exp_gnt(input int i);
        gnt_t g;
        g.idx   = i;
        g.addr  = tb_addr[i];
        g.we    = tb_we[i];
        g.wdata = tb_wdata[i];
        g.be    = tb_be[i];
        g.cyc   = cyc_cnt;
        exp_gnt_q.push_back(g);
    endtask

    task automatic drive_rsp(input int owner, input logic [31:0] d, input logic e);
        rsp_t r;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = d;
        mem_rsp_error = e;
        r.idx  = owner;
        r.data = d;
        r.err  = e;
        r.cyc  = cyc_cnt;
        exp_rsp_q.push_back(r);
    endtask

    task automatic idle_rsp();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_error = 1'b0;
    endtask

    // Monitor: match every grant and routed response against the scoreboard.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_gnt != 3'b000) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual m_gnt=%b expected none (cycle %0d)", m_gnt, cyc_cnt);
                end else begin
                    mon_g  = exp_gnt_q.pop_front();
                    mon_oh = 3'b001 << mon_g.idx;
                    chk("gnt_master", m_gnt, mon_oh);
                    chk("gnt_cycle", cyc_cnt, mon_g.cyc);
                    chk("gnt_addr", mem_addr, mon_g.addr);
                    chk("gnt_we", mem_we, mon_g.we);
                    chk("gnt_wdata", mem_wdata, mon_g.wdata);
                    chk("gnt_be", mem_be, mon_g.be);
                end
            end
            if (m_rsp_valid != 3'b000) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual m_rsp_valid=%b expected none (cycle %0d)", m_rsp_valid, cyc_cnt);
                end else begin
                    mon_r  = exp_rsp_q.pop_front();
                    mon_oh = 3'b001 << mon_r.idx;
                    chk("rsp_master", m_rsp_valid, mon_oh);
                    chk("rsp_cycle", cyc_cnt, mon_r.cyc);
                    chk("rsp_rdata", m_rsp_rdata, mon_r.data);
                    chk("rsp_error", m_rsp_error, mon_r.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        areset  = 1'b1;
        m_req   = 3'b111;
        m_addr  = '0;
        m_we    = '0;
        m_wdata = '0;
        m_be    = '0;
        mem_gnt = 1'b1;
        set_master(0, 32'h100, 1'b0, 32'h0, 4'hF);
        set_master(1, 32'h2000, 1'b1, 32'h2222_2222, 4'h3);
        set_master(2, 32'h3000, 1'b0, 32'h0, 4'hC);
        drive_rsp(0, 32'h1111_1111, 1'b1);
        void'(exp_rsp_q.pop_back());
        step();
        step();
        #2;
        // Reset state with requests and a response pending at the inputs
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_m_gnt", m_gnt, 3'b000);
        chk("rst_m_rsp_valid", m_rsp_valid, 3'b000);
        chk("rst_m_rsp_rdata", m_rsp_rdata, 32'h0);
        chk("rst_m_rsp_error", m_rsp_error, 1'b0);
        chk("rst_unexp_rsp", unexp_rsp, 1'b0);
        step();
        areset  = 1'b0;
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        idle_rsp();
        step();

        // Single read: grant in the request cycle, response two cycles later
        m_req   = 3'b001;
        mem_gnt = 1'b1;
        exp_gnt(0);
        #2;
        chk("rd_mem_req", mem_req, 1'b1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        step();
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        step();
        drive_rsp(0, 32'hDEAD_BEEF, 1'b0);
        step();
        idle_rsp();

        // Fairness: all request, rr_ptr starts at 1 after the single read
        set_master(0, 32'h1000, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 8; k++) begin
            m_req   = (k < 6) ? 3'b111 : 3'b000;
            mem_gnt = (k < 6);
            if (k < 6) exp_gnt(fair_order[k]);
            if (k >= 2) drive_rsp(fair_order[k-2], 32'hA000_0000 + 32'(k), (k == 4));
            else idle_rsp();
            step();
        end
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        idle_rsp();

        // Hold: master 1 write held while mem_gnt low, master 0 joins later
        set_master(1, 32'h200, 1'b1, 32'h1234, 4'hF);
        set_master(0, 32'h400, 1'b0, 32'h0, 4'h1);
        m_req = 3'b010;
        #2;
        chk("hold_req0", mem_req, 1'b1);
        chk("hold_addr0", mem_addr, 32'h200);
        chk("hold_we0", mem_we, 1'b1);
        chk("hold_wdata0", mem_wdata, 32'h1234);
        step();
        m_req = 3'b011;
        #2;
        chk("hold_addr1", mem_addr, 32'h200);
        step();
        #2;
        chk("hold_addr2", mem_addr, 32'h200);
        step();
        mem_gnt = 1'b1;
        exp_gnt(1);
        step();
        m_req = 3'b001;
        exp_gnt(0);
        #2;
        chk("hold_second_addr", mem_addr, 32'h400);
        step();
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        drive_rsp(1, 32'h0, 1'b0);
        step();
        drive_rsp(0, 32'h0000_0400, 1'b0);
        step();
        idle_rsp();

        // Full: four grants without responses, then stall until one returns
        for (int k = 0; k < 4; k++) begin
            m_req   = 3'b111;
            mem_gnt = 1'b1;
            exp_gnt(full_order[k]);
            step();
        end
        m_req = 3'b100;
        drive_rsp(1, 32'h0000_00F0, 1'b0);
        #2;
        chk("full_mem_req", mem_req, 1'b0);
        chk("full_mem_addr", mem_addr, 32'h0);
        step();
        idle_rsp();
        mem_gnt = 1'b0;
        #2;
        chk("full_reassert", mem_req, 1'b1);
        chk("full_reassert_addr", mem_addr, 32'h3000);
        step();
        mem_gnt = 1'b1;
        exp_gnt(2);
        step();
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        drive_rsp(2, 32'h0000_00F1, 1'b0);
        step();
        drive_rsp(0, 32'h0000_00F2, 1'b0);
        step();
        drive_rsp(1, 32'h0000_00F3, 1'b1);
        step();

        // Simultaneous push/pop with one outstanding (master 2), then drain
        m_req   = 3'b001;
        mem_gnt = 1'b1;
        exp_gnt(0);
        drive_rsp(2, 32'h0000_5555, 1'b0);
        step();
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        drive_rsp(0, 32'h0000_6666, 1'b0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0000_7777;
        #2;
        chk("unexp_no_route", m_rsp_valid, 3'b000);
        chk("unexp_before_edge", unexp_rsp, 1'b0);
        step();
        idle_rsp();
        #2;
        chk("unexp_set", unexp_rsp, 1'b1);
        step();
        #2;
        chk("unexp_sticky", unexp_rsp, 1'b1);
        step();

        // Reset mid-burst with three outstanding
        for (int k = 0; k < 3; k++) begin
            m_req   = 3'b111;
            mem_gnt = 1'b1;
            exp_gnt(burst_order[k]);
            step();
        end
        areset        = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0000_9999;
        #2;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_m_gnt", m_gnt, 3'b000);
        chk("midrst_rsp_valid", m_rsp_valid, 3'b000);
        chk("midrst_rsp_rdata", m_rsp_rdata, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_unexp", unexp_rsp, 1'b0);
        step();
        areset = 1'b0;
        idle_rsp();
        m_req   = 3'b111;
        mem_gnt = 1'b1;
        exp_gnt(0);
        step();
        m_req   = 3'b000;
        mem_gnt = 1'b0;
        step();
        drive_rsp(0, 32'h0000_AAAA, 1'b0);
        #2;
        chk("post_rst_unexp", unexp_rsp, 1'b0);
        step();
        idle_rsp();
        repeat (3) step();

        chk("gnt_queue_drained", exp_gnt_q.size(), 0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
